// File: rtl/mac8_accumulator.sv
// ---------------------------------------------------------------------------
// mac8_accumulator
//
// Accumulation stage of the MAC8 datapath, placed directly after the 8x8
// Vedic multiplier. It takes one 16-bit product per beat and sums the
// products of a group into a wide accumulator. The group is delimited by
// first/last markers. Each finished group is presented on a registered
// valid/ready output, together with a term count and an overflow flag.
//
// Compile-time option:
//   MAC8_SAT_EN  defined   -> saturating accumulation (clamps at 2^ACC_W-1)
//                undefined -> wrapping accumulation (modulo 2^ACC_W)
//   In both modes out_ovf reports any carry out of ACC_W within the group.
//
// Parameters:
//   ACC_W  accumulator / result width (legal 16..32)
//   CNT_W  term-counter width
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   product beat valid
//   in_ready   stage can accept a beat (= !out_valid || out_ready)
//   in_prod    16-bit product from the multiplier
//   in_first   beat opens a new group
//   in_last    beat closes the current group
//   out_valid  result register holds an unconsumed result
//   out_ready  downstream accepts the result
//   out_acc    group sum
//   out_count  number of terms in the group (saturating)
//   out_ovf    overflow occurred in the group
// ---------------------------------------------------------------------------
module mac8_accumulator #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_prod,
   input  logic             in_first,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   // IDLE means no group is open, and ACCUM means a partial sum is being built.
   typedef enum logic {
      IDLE,
      ACCUM
   } StateType;

   StateType         state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic             beatAccepted;
   logic             startGroup;
   logic [ACC_W:0]   sumWide;
   logic [ACC_W-1:0] nextAcc;
   logic [CNT_W-1:0] nextCnt;
   logic             nextOvf;

   // The stage can take a beat whenever the result register is empty or is
   // being drained this cycle. This signal deliberately ignores in_valid, so
   // upstream can rely on it without a combinational loop. It also makes the
   // stage stall every beat (last or not) while a result is pending.
   always_comb begin
      in_ready     = !out_valid || out_ready;
      beatAccepted = in_valid && in_ready;
   end

   // Compute what the running accumulator would become if the current beat
   // is accepted. A beat that arrives while IDLE opens a group even when
   // in_first is low. A beat with in_first set during ACCUM drops the partial
   // sum. The sum is one bit wider than the accumulator so that its top bit
   // is the carry that drives the overflow flag and, in saturating mode, the
   // clamp. Once the accumulator has clamped at all-ones, any further nonzero
   // product carries again, so the value stays clamped for the rest of the group.
   always_comb begin
      startGroup = (state == IDLE) || in_first;
      sumWide    = {1'b0, acc} + (ACC_W+1)'(in_prod);
      nextAcc    = ACC_W'(in_prod);
      nextCnt    = CNT_W'(1);
      nextOvf    = 1'b0;
      if (!startGroup) begin
`ifdef MAC8_SAT_EN
         nextAcc = sumWide[ACC_W] ? {ACC_W{1'b1}} : sumWide[ACC_W-1:0];
`else
         nextAcc = sumWide[ACC_W-1:0];
`endif
         nextCnt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
         nextOvf = ovf | sumWide[ACC_W];
      end
   end

   // This block holds the group FSM, the running accumulator and the
   // registered result. A result that is consumed (out_valid && out_ready)
   // clears out_valid. A last beat accepted in the same cycle overrides that
   // clear, so back-to-back groups stream without a bubble. A last beat
   // hands the updated values to the output registers and returns the
   // internal state to an empty IDLE group.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (beatAccepted) begin
            if (in_last) begin
               out_acc   <= nextAcc;
               out_count <= nextCnt;
               out_ovf   <= nextOvf;
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
               ovf       <= 1'b0;
               state     <= IDLE;
            end else begin
               acc       <= nextAcc;
               cnt       <= nextCnt;
               ovf       <= nextOvf;
               state     <= ACCUM;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac8_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac8_accumulator
//
// Self-checking bench for mac8_accumulator. Two instances share the same
// stimulus: one at the default width (ACC_W=24) and one at ACC_W=16, where
// overflow is easy to reach. The reference model keeps the products of the
// open group in a queue. When a group closes, the model forms the result
// with plain integer arithmetic: a true sum, then wrap or clamp, then
// compare against 2^ACC_W for the overflow flag.
// Honours MAC8_SAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mac8_accumulator;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic [15:0] inProd;
   logic        inFirst;
   logic        inLast;
   logic        outReady;

   logic        inReadyA, outValidA, outOvfA;
   logic [23:0] outAccA;
   logic [7:0]  outCountA;
   logic        inReadyB, outValidB, outOvfB;
   logic [15:0] outAccB;
   logic [7:0]  outCountB;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model state
   int          groupTerms[$];
   logic        groupOpen;
   logic        expValid;
   logic [31:0] expAccA, expAccB, expCount;
   logic        expOvfA, expOvfB;

   mac8_accumulator #(.ACC_W(24), .CNT_W(8)) dutA (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReadyA), .in_prod(inProd),
      .in_first(inFirst), .in_last(inLast),
      .out_valid(outValidA), .out_ready(outReady),
      .out_acc(outAccA), .out_count(outCountA), .out_ovf(outOvfA)
   );

   mac8_accumulator #(.ACC_W(16), .CNT_W(8)) dutB (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReadyB), .in_prod(inProd),
      .in_first(inFirst), .in_last(inLast),
      .out_valid(outValidB), .out_ready(outReady),
      .out_acc(outAccB), .out_count(outCountB), .out_ovf(outOvfB)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, and report it on mismatch
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      assert (got === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Result of the current group for a given accumulator width
   function automatic void groupResult(input int w, output logic [31:0] a, output logic o);
      longint total = 0;
      longint limit = longint'(1) << w;
      foreach (groupTerms[i]) total += groupTerms[i];
      o = (total >= limit);
`ifdef MAC8_SAT_EN
      a = o ? 32'(limit - 1) : 32'(total);
`else
      a = 32'(total % limit);
`endif
   endfunction

   // Compare every registered output of both instances with the model
   task automatic checkAll(input string tag);
      checkOutput({tag, " out_valid A"}, 32'(outValidA), 32'(expValid));
      checkOutput({tag, " out_acc A"},   32'(outAccA),   expAccA);
      checkOutput({tag, " out_count A"}, 32'(outCountA), expCount);
      checkOutput({tag, " out_ovf A"},   32'(outOvfA),   32'(expOvfA));
      checkOutput({tag, " out_valid B"}, 32'(outValidB), 32'(expValid));
      checkOutput({tag, " out_acc B"},   32'(outAccB),   expAccB);
      checkOutput({tag, " out_count B"}, 32'(outCountB), expCount);
      checkOutput({tag, " out_ovf B"},   32'(outOvfB),   32'(expOvfA ? expOvfB : expOvfB));
   endtask

   // Drive one beat (called just after a rising edge). Check in_ready, update
   // the model for that edge, then check the registered outputs just after the edge.
   task automatic applyStimulus(input string tag, input logic v, input logic [15:0] p,
                                input logic f, input logic l, input logic ordy);
      logic expReady;
      logic [31:0] a;
      logic o;
      inValid  = v;
      inProd   = p;
      inFirst  = f;
      inLast   = l;
      outReady = ordy;
      #1;
      expReady = !expValid || ordy;
      checkOutput({tag, " in_ready A"}, 32'(inReadyA), 32'(expReady));
      checkOutput({tag, " in_ready B"}, 32'(inReadyB), 32'(expReady));
      if (expValid && ordy) expValid = 1'b0;
      if (v && expReady) begin
         if (!groupOpen || f) groupTerms.delete();
         groupTerms.push_back(int'(p));
         groupOpen = 1'b1;
         if (l) begin
            groupResult(24, a, o);
            expAccA = a;
            expOvfA = o;
            groupResult(16, a, o);
            expAccB = a;
            expOvfB = o;
            expCount = (groupTerms.size() > 255) ? 32'd255 : 32'(groupTerms.size());
            expValid = 1'b1;
            groupOpen = 1'b0;
            groupTerms.delete();
         end
      end
      @(posedge clk);
      #1;
      checkAll(tag);
   endtask

   // Hold reset for two edges with idle inputs, then clear the model
   task automatic applyReset();
      rst      = 1'b1;
      inValid  = 1'b0;
      inProd   = '0;
      inFirst  = 1'b0;
      inLast   = 1'b0;
      outReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      groupTerms.delete();
      groupOpen = 1'b0;
      expValid  = 1'b0;
      expAccA   = '0;
      expAccB   = '0;
      expCount  = '0;
      expOvfA   = 1'b0;
      expOvfB   = 1'b0;
      checkAll("reset");
      checkOutput("reset in_ready A", 32'(inReadyA), 32'd1);
   endtask

   initial begin
      applyReset();

      // Three-term group
      applyStimulus("g3 b1", 1, 16'h0006, 1, 0, 1);
      applyStimulus("g3 b2", 1, 16'h0010, 0, 0, 1);
      applyStimulus("g3 b3", 1, 16'h0100, 0, 1, 1);
      checkOutput("g3 literal acc", 32'(outAccA), 32'h0000_0116);
      checkOutput("g3 literal count", 32'(outCountA), 32'd3);

      // Single-term group
      applyStimulus("single", 1, 16'hFE01, 1, 1, 1);
      checkOutput("single literal acc", 32'(outAccA), 32'h0000_FE01);

      // Overflow on the 16-bit instance
      applyStimulus("ovf b1", 1, 16'hFE01, 1, 0, 1);
      applyStimulus("ovf b2", 1, 16'hFE01, 0, 1, 1);
`ifdef MAC8_SAT_EN
      checkOutput("ovf literal acc16", 32'(outAccB), 32'h0000_FFFF);
`else
      checkOutput("ovf literal acc16", 32'(outAccB), 32'h0000_FC02);
`endif
      checkOutput("ovf literal flag16", 32'(outOvfB), 32'd1);
      checkOutput("ovf literal acc24", 32'(outAccA), 32'h0001_FC02);

      // Stall: result pending, downstream not ready, input pushing
      applyStimulus("stall load", 1, 16'h0042, 1, 1, 0);
      for (int i = 0; i < 5; i++) applyStimulus("stall hold", 1, 16'h1234, 1, 0, 0);
      applyStimulus("stall release", 1, 16'h0007, 1, 0, 1);
      applyStimulus("stall close", 1, 16'h0003, 0, 1, 1);

      // Back-to-back single-term groups
      applyStimulus("b2b 1", 1, 16'h0001, 1, 1, 1);
      applyStimulus("b2b 2", 1, 16'h0002, 1, 1, 1);
      applyStimulus("b2b 3", 1, 16'h0003, 1, 1, 1);
      applyStimulus("b2b drain", 0, 16'h0000, 0, 0, 1);

      // First in mid-group discards, IDLE open without first
      applyStimulus("restart b1", 1, 16'h0100, 0, 0, 1);
      applyStimulus("restart b2", 1, 16'h0200, 1, 0, 1);
      applyStimulus("restart b3", 1, 16'h0020, 0, 1, 1);

      // Long group: count saturation and 24-bit overflow
      for (int i = 0; i < 299; i++) applyStimulus("long", 1, 16'hFFFF, (i == 0), 0, 1);
      applyStimulus("long last", 1, 16'hFFFF, 0, 1, 1);

      // Reset in the middle of an open group with a result pending
      applyStimulus("mid b1", 1, 16'h0011, 1, 0, 1);
      applyStimulus("mid b2", 1, 16'h0022, 0, 0, 1);
      applyReset();
      applyStimulus("after rst", 1, 16'h0005, 0, 1, 1);
      checkOutput("after rst literal acc", 32'(outAccA), 32'd5);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus("random",
                       ($urandom_range(0, 9) < 8),
                       16'($urandom),
                       ($urandom_range(0, 9) < 2),
                       ($urandom_range(0, 9) < 3),
                       ($urandom_range(0, 9) < 7));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mac8_accumulator.md
# mac8_accumulator

Accumulation stage of the MAC8 datapath, placed directly downstream of the 8x8 Vedic multiplier. It consumes one 16-bit product per beat and sums the products of a group, delimited by first/last markers, into a wide accumulator. It presents each finished group result, with a term count and an overflow flag, on a registered valid/ready output. Overflow handling is either wrap or saturate, selected at compile time.

## Interface
- ACC_W, 24: accumulator and result width; legal range 16..32.
- CNT_W, 8: term-counter width.
- clk  in  1  rising-edge clock, the single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  stage can accept a beat.
- in_prod  in  16  product from the multiplier (P).
- in_first  in  1  beat opens a new group.
- in_last  in  1  beat closes the current group.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  group sum.
- out_count  out  CNT_W  number of terms in the group.
- out_ovf  out  1  overflow occurred in the group.

## Operation
- Beat accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_valid and out_ready. It is independent of in_valid.
- FSM states:
  - IDLE: no open group.
  - ACCUM: group open.
- Accepted beat, state IDLE or in_first=1: acc <= zero-extended in_prod; cnt <= 1; ovf <= 0. A group opened from IDLE without in_first is treated as if in_first were set.
- Accepted beat, state ACCUM and in_first=0: sum = acc + in_prod, computed ACC_W+1 bits wide; cnt <= cnt+1, saturating at all-ones; ovf <= ovf | sum[ACC_W].
- in_first during ACCUM discards the partial group silently.
- in_last on an accepted beat:
  - The updated acc, cnt and ovf values are loaded into out_acc, out_count and out_ovf.
  - out_valid <= 1.
  - Internal acc and cnt clear to 0; FSM -> IDLE.
- Accepted beat with in_last=0: FSM -> ACCUM.
- in_first=in_last=1: single-term group; out_acc = in_prod, out_count = 1, out_ovf = 0.
- Output handshake: out_valid && out_ready clears out_valid, unless a last beat is accepted in the same cycle. In that case the output registers reload and out_valid stays 1.
- The output registers hold stable while out_valid=1 and out_ready=0.
- While output is stalled, in_ready=0 for all beats, including non-last beats.
- in_valid=0: no state change.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_acc=0, out_count=0, out_ovf=0.
  - Internal: acc=0, cnt=0, FSM=IDLE.
  - in_ready: reads 1 after reset.
- Reset asserted mid-group discards the partial sum and any pending result. The first cycle after rst deasserts is ready for a beat.
- Latency: the result is visible on out_* the cycle after the last beat is accepted.
- Throughput: one beat per clock when out_ready is held high. Back-to-back groups need no bubble.
- No combinational path from in_valid/in_prod to any output.

## Configuration
- MAC8_SAT_EN defined: saturating mode.
  - On carry out of ACC_W, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the group.
  - out_ovf is set.
- MAC8_SAT_EN undefined: wrapping mode.
  - acc wraps modulo 2^ACC_W.
  - out_ovf is still set on carry.

## Test plan
- Three beats 0x0006, 0x0010, 0x0100 (first on beat 1, last on beat 3), out_ready=1 -> one cycle after beat 3: out_valid=1, out_acc=0x000116, out_count=3, out_ovf=0.
- Single beat 0xFE01 with first=last=1 -> out_acc=0x00FE01, out_count=1, out_ovf=0.
- ACC_W=16, two beats 0xFE01 then 0xFE01 (last):
  - MAC8_SAT_EN defined -> out_acc=0xFFFF, out_ovf=1.
  - MAC8_SAT_EN undefined -> out_acc=0xFC02, out_ovf=1.
- Result pending with out_ready=0, in_valid=1 -> in_ready=0; out_* stable for 5 cycles. Raising out_ready accepts both sides in the same cycle, and the new group's beat is accepted.
- Back-to-back single-term groups 0x0001, 0x0002, 0x0003 on consecutive cycles, out_ready=1 -> out_acc sequence 1, 2, 3 on consecutive cycles, with out_valid continuously 1.
- rst pulsed after 2 beats of an open group -> all outputs 0. The next group, 0x0005 with last, yields out_acc=5 and out_count=1.
